pos_cell_reader: RTL and testbench

- Read-side sequencer for one position cell memory (single-port M20K, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz, posy, posx}).
- On a start pulse it fetches the count, then streams every particle word in address order to the downstream force/motion pipeline over a valid/ready interface.
- A small credit-controlled output FIFO absorbs the fixed RAM latency so downstream backpressure never loses data.

---
 rtl/pos_cell_reader.sv | 208 ++++++++++++++++++++
 tb/tb_pos_cell_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pos_cell_reader.sv
// Read-side sequencer for one position cell RAM: fetches the particle count,
// then streams words 1..count through a credit-controlled output FIFO.
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LAT       = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  cnt_err,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last
);

  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int TOT_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_REQ, S_CNT_WAIT, S_STREAM, S_DRAIN, S_FIN
  } state_t;

  typedef struct packed {
    logic                  vld;
    logic                  is_cnt;
    logic [ADDR_WIDTH-1:0] addr;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pos;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  last;
  } entry_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cnt_err_q, cnt_err_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  tag_t                  tag_q [RD_LAT];
  tag_t                  tag_d [RD_LAT];
  entry_t                fifo_q [FIFO_DEPTH];
  entry_t                fifo_d [FIFO_DEPTH];
  logic [FC_W-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic                  out_valid_q, out_valid_d;

  logic                  push, pop, credit;
  entry_t                push_entry;
  logic [FC_W-1:0]       wr_pos;
  logic [TOT_W-1:0]      inflight, outstanding;
  logic [ADDR_WIDTH-1:0] cnt_raw;

  // Read tracking and FIFO; the head slot fifo_q[0] drives out_* directly.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    tag_d[0].vld    = rd_en_q;
    tag_d[0].is_cnt = (state_q == S_CNT_REQ);
    tag_d[0].addr   = rd_addr_q;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];

    push            = tag_q[RD_LAT-1].vld && !tag_q[RD_LAT-1].is_cnt;
    pop             = out_valid_q && out_ready;
    push_entry.pos  = rd_data;
    push_entry.idx  = tag_q[RD_LAT-1].addr;
    push_entry.last = (tag_q[RD_LAT-1].addr == count_q);

    for (int i = 0; i < FIFO_DEPTH; i++) fifo_d[i] = fifo_q[i];
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
    end
    wr_pos = fifo_cnt_q - FC_W'(pop);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (push && wr_pos == FC_W'(i)) fifo_d[i] = push_entry;
    end
    fifo_cnt_d  = fifo_cnt_q + FC_W'(push) - FC_W'(pop);
    out_valid_d = (fifo_cnt_d != '0);

    // Data reads issued but not yet in the FIFO; the count read is excluded.
    inflight = TOT_W'(rd_en_q && state_q != S_CNT_REQ);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + TOT_W'(tag_q[i].vld && !tag_q[i].is_cnt);
    end
    // The pop in this cycle frees its slot, which keeps one read per cycle going.
    outstanding = TOT_W'(fifo_cnt_q) + inflight - TOT_W'(pop);
    credit      = (outstanding < TOT_W'(FIFO_DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_err_d   = cnt_err_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    count_d     = count_q;
    next_addr_d = next_addr_q;
    cnt_raw     = rd_data[ADDR_WIDTH-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CNT_REQ;
          busy_d    = 1'b1;
          cnt_err_d = 1'b0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      S_CNT_REQ: state_d = S_CNT_WAIT;
      S_CNT_WAIT: begin
        if (tag_q[RD_LAT-1].vld && tag_q[RD_LAT-1].is_cnt) begin
          if (cnt_raw > CNT_MAX) begin
            cnt_raw   = CNT_MAX;
            cnt_err_d = 1'b1;
          end
          count_d = cnt_raw;
          if (cnt_raw == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            // The FIFO is empty here, so the first read needs no credit check.
            rd_en_d     = 1'b1;
            rd_addr_d   = ADDR_WIDTH'(1);
            next_addr_d = ADDR_WIDTH'(2);
            state_d     = (cnt_raw == ADDR_WIDTH'(1)) ? S_DRAIN : S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (credit) begin
          rd_en_d     = 1'b1;
          rd_addr_d   = next_addr_q;
          next_addr_d = next_addr_q + ADDR_WIDTH'(1);
          if (next_addr_q == count_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outstanding == '0) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_err_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      count_q     <= '0;
      next_addr_q <= '0;
      fifo_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      // NOTE: the FIFO is a handful of flops, not RAM, and its head is the visible
      // out_* port, so it is reset rather than left undefined.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_err_q   <= cnt_err_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      count_q     <= count_d;
      next_addr_q <= next_addr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cnt_err   = cnt_err_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_pos   = fifo_q[0].pos;
  assign out_idx   = fifo_q[0].idx;
  assign out_last  = fifo_q[0].last;

endmodule

// File: tb/tb_pos_cell_reader.sv
// Self-checking bench for pos_cell_reader: table of cell runs plus a reset-abort
// sequence, with a 2-cycle-latency RAM model and an expected-word scoreboard.
module tb_pos_cell_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, cnt_err, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_pos;
  logic [AW-1:0] out_idx;

  pos_cell_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .RD_LAT(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cnt_err(cnt_err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Cell RAM model: registered address, registered output.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ram_q1;
  always @(posedge clk) begin
    if (rd_en) ram_q1 <= mem[rd_addr];
    rd_data <= ram_q1;
  end

  typedef struct packed {
    logic [DW-1:0] pos;
    logic [AW-1:0] idx;
    logic          last;
  } sb_t;

  typedef struct {
    int cnt_word;
    bit toggle;
    bit restart;
    int exp_n;
    bit exp_err;
    int exp_done;
  } vec_t;

  sb_t  sb_q [$];
  vec_t vecs [5];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_word(input string name, input sb_t got, input sb_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got idx=%0d last=%0b pos=%h expected idx=%0d last=%0b pos=%h",
                  name, got.idx, got.last, got.pos, exp.idx, exp.last, exp.pos);
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    logic [31:0] u;
    u = i;
    return {32'hC000_0000 + u, 32'hB000_0000 + u * 3, 32'hA000_0000 + u * 7};
  endfunction

  task automatic run_case(input vec_t v);
    int  done_cyc = -1, n_done = 0, busy_first = -1, busy_last = -1, busy_after = 0;
    int  first_valid = -1, valid_after = 0, n_hs = 0, stall_err = 0;
    int  n_cnt_rd = 0, n_data_rd = 0, outst = 0, max_out = 0, err_at_1 = -1;
    sb_t got;
    mem[0] = DW'(v.cnt_word);
    sb_q.delete();
    for (int i = 1; i <= v.exp_n; i++)
      sb_q.push_back('{pos: word_of(i), idx: AW'(i), last: (i == v.exp_n)});

    for (int t = 0; t < 1000; t++) begin
      @(posedge clk); #1;
      start     = (t == 0) || (v.restart && (t == 2 || t == 5));
      out_ready = v.toggle ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (t == 1) err_at_1 = int'(cnt_err);
      if (busy) begin
        if (busy_first < 0) busy_first = t;
        busy_last = t;
        if (done_cyc >= 0 && t > done_cyc) busy_after++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = t;
      end
      if (rd_en) begin
        if (rd_addr == '0) n_cnt_rd++;
        else begin n_data_rd++; outst++; end
      end
      if (outst > max_out) max_out = outst;
      if (out_valid) begin
        if (first_valid < 0) first_valid = t;
        if (done_cyc >= 0 && t > done_cyc) valid_after++;
        got = '{pos: out_pos, idx: out_idx, last: out_last};
        if (out_ready) begin
          n_hs++;
          outst--;
          if (sb_q.size() == 0) check_word("extra_word", got, '0);
          else check_word("word", got, sb_q.pop_front());
        end else if (sb_q.size() != 0 && got !== sb_q[0]) begin
          stall_err++;
        end
      end
      if (done_cyc >= 0 && t >= done_cyc + 3) break;
    end
    start = 1'b0;

    check_int("err_cleared_on_start", err_at_1, 0);
    check_int("done_seen", int'(done_cyc >= 0), 1);
    check_int("done_count", n_done, 1);
    if (v.exp_done >= 0) check_int("done_cycle", done_cyc, v.exp_done);
    check_int("busy_first", busy_first, 1);
    check_int("busy_last", busy_last, done_cyc);
    check_int("busy_after_done", busy_after, 0);
    check_int("words_emitted", n_hs, v.exp_n);
    check_int("words_missing", sb_q.size(), 0);
    check_int("first_valid", first_valid, (v.exp_n > 0) ? 7 : -1);
    check_int("valid_after_done", valid_after, 0);
    check_int("stall_unstable", stall_err, 0);
    check_int("count_reads", n_cnt_rd, 1);
    check_int("data_reads", n_data_rd, v.exp_n);
    check_int("credit_bound", int'(max_out <= 4), 1);
    check_int("cnt_err_after_done", int'(cnt_err), int'(v.exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int activity;
    int saw_valid;
    vecs[0] = '{3,   1'b0, 1'b0, 3,   1'b0, 10};
    vecs[1] = '{0,   1'b0, 1'b0, 0,   1'b0, 4};
    vecs[2] = '{10,  1'b1, 1'b0, 10,  1'b0, -1};
    vecs[3] = '{250, 1'b0, 1'b0, 219, 1'b1, 226};
    vecs[4] = '{5,   1'b0, 1'b1, 5,   1'b0, 12};
    for (int i = 1; i < 256; i++) mem[i] = word_of(i);

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_ctrl", int'({busy, done, cnt_err, rd_en, out_valid, out_last}), 0);
    check_int("reset_addr_idx", int'({rd_addr, out_idx}), 0);
    check_int("reset_pos_zero", int'(out_pos == '0), 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 5; k++) begin
      run_case(vecs[k]);
      repeat (2) @(posedge clk);
    end

    // Reset at cycle 8 of a count-20 run, with reads still in flight.
    mem[0] = DW'(20);
    saw_valid = 0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      start = (t == 0);
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) saw_valid = 1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b1;
    #1;
    check_int("abort_was_active", saw_valid, 1);
    check_int("abort_ctrl", int'({busy, done, cnt_err, rd_en, out_valid, out_last}), 0);
    check_int("abort_addr_idx", int'({rd_addr, out_idx}), 0);
    check_int("abort_pos_zero", int'(out_pos == '0), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    activity = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid || busy || done || rd_en) activity++;
    end
    check_int("post_abort_quiet", activity, 0);
    run_case(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
